// File: rtl/draw_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_engine_if
// Description : Request handshake and VGA plot bus between a game controller
//               (master) and the draw engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_engine_if #(
    parameter int COL_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic             req_obj;
    logic [7:0]       req_x;
    logic [6:0]       req_y;
    logic [7:0]       req_w;
    logic [6:0]       req_h;
    logic [COL_W-1:0] req_colour;
    logic             req_erase;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [COL_W-1:0] vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_obj, req_x, req_y, req_w, req_h, req_colour, req_erase,
        input  req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  req_valid, req_obj, req_x, req_y, req_w, req_h, req_colour, req_erase,
        output req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/draw_engine.sv
`default_nettype none
// ============================================================================
// Module      : draw_engine
// Description : Rasterises a wall column (with a gap) or a bird rectangle into
//               the VGA frame, one pixel per clock, with a done pulse at end.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_engine #(
    parameter int               SCREEN_W  = 160,
    parameter int               SCREEN_H  = 120,
    parameter int               GAP_H     = 40,
    parameter int               COL_W     = 3,
    parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
    input  wire               clk,
    input  wire               resetn,
    draw_engine_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Captured command; colour already resolved against the erase flag
    logic             obj_q, obj_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [7:0]       w_q, w_d;
    logic [6:0]       h_q, h_d;
    logic [COL_W-1:0] colour_q, colour_d;

    // Raster position of the pixel currently on the outputs
    logic [7:0]       cx_q, cx_d;
    logic [6:0]       cy_q, cy_d;

    logic [7:0]       vga_x_q, vga_x_d;
    logic [6:0]       vga_y_q, vga_y_d;
    logic [COL_W-1:0] vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_ready_q, req_ready_d;

    logic             emit;
    logic             last;
    logic [8:0]       px;
    logic [7:0]       py;
    logic [7:0]       gap_end;

    // Next-state, counter advance and next pixel for the registered outputs
    always_comb begin
        state_d      = state_q;
        obj_d        = obj_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        colour_d     = colour_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        req_ready_d  = 1'b0;
        emit         = 1'b0;
        last         = (cx_q == w_q - 8'd1) && (cy_q == h_q - 7'd1);

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    if ((bus.req_w == 8'd0) || (bus.req_obj && (bus.req_h == 7'd0))) begin
                        // Nothing to rasterise: acknowledge straight away
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        obj_d    = bus.req_obj;
                        x_d      = bus.req_x;
                        y_d      = bus.req_y;
                        w_d      = bus.req_w;
                        h_d      = bus.req_obj ? bus.req_h : 7'(SCREEN_H);
                        colour_d = bus.req_erase ? BG_COLOUR : bus.req_colour;
                        cx_d     = 8'd0;
                        cy_d     = 7'd0;
                        state_d  = DRAW;
                        busy_d   = 1'b1;
                        emit     = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (last) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    emit   = 1'b1;
                    if (cx_q == w_q - 8'd1) begin
                        cx_d = 8'd0;
                        cy_d = cy_q + 7'd1;
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            FIN: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        // One bit of headroom so wrap-around lands off-screen instead of visible
        px      = {1'b0, x_d} + {1'b0, cx_d};
        py      = obj_d ? ({1'b0, y_d} + {1'b0, cy_d}) : {1'b0, cy_d};
        gap_end = {1'b0, y_d} + 8'(GAP_H);

        if (emit) begin
            vga_x_d      = px[7:0];
            vga_y_d      = py[6:0];
            vga_colour_d = colour_d;
            vga_plot_d   = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H)) &&
                           !(!obj_d && (py >= {1'b0, y_d}) && (py < gap_end));
        end
    end

    // State and output registers; reset aborts any command without a done pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            obj_q        <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            w_q          <= 8'd0;
            h_q          <= 7'd0;
            colour_q     <= '0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            obj_q        <= obj_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            colour_q     <= colour_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_engine
// Description : Self-checking bench for draw_engine against a behavioural
//               raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_engine;

    localparam int SW  = 160;
    localparam int SH  = 120;
    localparam int GAP = 40;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    draw_engine_if #(.COL_W(3)) bus ();

    draw_engine #(
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .GAP_H    (GAP),
        .COL_W    (3),
        .BG_COLOUR(3'b000)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    // Expected pixel number k of a command, straight from the raster rules
    task automatic model_pixel(input bit obj, input int x, input int y, input int w,
                               input int k, output int ex, output int ey, output bit ep);
        int c;
        int r;
        int ax;
        int ay;
        c  = k % w;
        r  = k / w;
        ax = x + c;
        ay = (obj ? y : 0) + r;
        ep = (ax < SW) && (ay < SH) && !(!obj && ay >= y && ay < y + GAP);
        ex = ax % 256;
        ey = ay % 128;
    endtask

    task automatic drive(input bit obj, input int x, input int y, input int w,
                         input int h, input logic [2:0] col, input bit erase);
        bus.req_obj    = obj;
        bus.req_x      = 8'(x);
        bus.req_y      = 7'(y);
        bus.req_w      = 8'(w);
        bus.req_h      = 7'(h);
        bus.req_colour = col;
        bus.req_erase  = erase;
    endtask

    task automatic run_cmd(input string name, input bit obj, input int x, input int y,
                           input int w, input int h, input logic [2:0] col,
                           input bit erase, output int plots);
        int n;
        int ex;
        int ey;
        int exp_plots;
        int guard;
        bit ep;
        logic [2:0] ecol;
        guard = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL %s ready_timeout: req_ready=%b want 1", name, bus.req_ready);
            plots = 0;
            return;
        end
        drive(obj, x, y, w, h, col, erase);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = ((w == 0) || (obj && h == 0)) ? 0 : w * (obj ? h : SH);
        ecol = erase ? 3'b000 : col;
        plots = 0;
        exp_plots = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            model_pixel(obj, x, y, w, k, ex, ey, ep);
            total++;
            if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy, bus.done, bus.req_ready}
                !== {ep, 8'(ex), 7'(ey), ecol, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL %s pixel%0d: got plot=%b x=%0d y=%0d col=%b busy=%b done=%b rdy=%b want plot=%b x=%0d y=%0d col=%b busy=1 done=0 rdy=0",
                         name, k, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.busy,
                         bus.done, bus.req_ready, ep, ex, ey, ecol);
            end
            if (bus.vga_plot === 1'b1) plots++;
            if (ep) exp_plots++;
        end
        @(negedge clk);
        total++;
        if ({bus.done, bus.vga_plot, bus.busy, bus.req_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL %s fin: got done=%b plot=%b busy=%b rdy=%b want 1 0 0 0",
                     name, bus.done, bus.vga_plot, bus.busy, bus.req_ready);
        end
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.done} !== 2'b10) begin
            bad++;
            $display("FAIL %s idle: got rdy=%b done=%b want 1 0", name, bus.req_ready, bus.done);
        end
        total++;
        if (plots != exp_plots) begin
            bad++;
            $display("FAIL %s plot_count: got %0d want %0d", name, plots, exp_plots);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done, bus.req_ready}
            !== {8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got x=%0d y=%0d col=%b plot=%b busy=%b done=%b rdy=%b want zeros rdy=1",
                     bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done, bus.req_ready);
        end
        resetn = 1'b1;
    endtask

    task automatic test_bird_basic();
        int p;
        run_cmd("bird_basic", 1'b1, 10, 20, 3, 2, 3'b110, 1'b0, p);
    endtask

    task automatic test_wall();
        int p;
        run_cmd("wall", 1'b0, 100, 30, 2, 0, 3'b010, 1'b0, p);
        total++;
        if (p != 160) begin
            bad++;
            $display("FAIL wall_plotted: got %0d want 160", p);
        end
    endtask

    task automatic test_clip_erase();
        int p;
        run_cmd("clip_erase", 1'b1, 158, 118, 4, 4, 3'b111, 1'b1, p);
        total++;
        if (p != 4) begin
            bad++;
            $display("FAIL clip_plotted: got %0d want 4", p);
        end
    endtask

    task automatic test_empty();
        int p;
        run_cmd("empty_w", 1'b1, 50, 50, 0, 3, 3'b001, 1'b0, p);
        run_cmd("empty_h", 1'b1, 50, 50, 3, 0, 3'b001, 1'b0, p);
    endtask

    task automatic test_reset_mid();
        int p;
        int dones;
        @(negedge clk);
        drive(1'b1, 40, 40, 5, 5, 3'b101, 1'b0);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done, bus.req_ready}
            !== {8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL midreset_state: got x=%0d y=%0d col=%b plot=%b busy=%b done=%b rdy=%b want zeros rdy=1",
                     bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done, bus.req_ready);
        end
        resetn = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL midreset_done: got %0d done pulses want 0", dones);
        end
        run_cmd("after_reset", 1'b1, 7, 9, 2, 3, 3'b011, 1'b0, p);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int ex;
        int ey;
        bit ep;
        @(negedge clk);
        drive(1'b1, 5, 5, 2, 2, 3'b011, 1'b0);
        bus.req_valid = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) @(negedge clk);
            if (t >= 1 && t <= 4) begin
                model_pixel(1'b1, 5, 5, 2, t - 1, ex, ey, ep);
            end else if (t >= 7 && t <= 10) begin
                model_pixel(1'b1, 70, 80, 2, t - 7, ex, ey, ep);
            end
            if ((t >= 1 && t <= 4) || (t >= 7 && t <= 10)) begin
                total++;
                if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.done} !== {ep, 8'(ex), 7'(ey), 1'b0}) begin
                    bad++;
                    $display("FAIL b2b t%0d: got plot=%b x=%0d y=%0d done=%b want plot=%b x=%0d y=%0d done=0",
                             t, bus.vga_plot, bus.vga_x, bus.vga_y, bus.done, ep, ex, ey);
                end
            end else if (t == 5 || t == 11) begin
                total++;
                if ({bus.done, bus.vga_plot} !== 2'b10) begin
                    bad++;
                    $display("FAIL b2b done t%0d: got done=%b plot=%b want 1 0", t, bus.done, bus.vga_plot);
                end
            end
            if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) begin
                acc.push_back(t);
                @(posedge clk);
                #1;
                if (acc.size() == 1) drive(1'b1, 70, 80, 2, 2, 3'b100, 1'b0);
                else bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        total++;
        if (acc.size() != 2) begin
            bad++;
            $display("FAIL b2b accepts: got %0d want 2", acc.size());
        end else if (acc[1] - acc[0] != 6) begin
            bad++;
            $display("FAIL b2b spacing: got %0d want 6", acc[1] - acc[0]);
        end
    endtask

    task automatic test_random();
        int p;
        bit obj;
        int x;
        int w;
        for (int i = 0; i < 25; i++) begin
            obj = 1'($urandom % 2);
            x   = ($urandom % 3 == 0) ? 150 + int'($urandom % 106) : int'($urandom % 256);
            w   = obj ? int'($urandom % 6) : int'($urandom % 3);
            run_cmd("random", obj, x, int'($urandom % 128), w, int'($urandom % 6),
                    3'($urandom), 1'($urandom % 2), p);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 3'b000, 1'b0);
        test_reset();
        test_bird_basic();
        test_wall();
        test_clip_erase();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
